// File: rtl/piano_key_ctrl.sv
// Piano note front-end: synchronises and debounces 7 note keys and 2 octave buttons,
// picks one note (highest index wins), enforces a minimum note length, tracks the octave.
module piano_key_ctrl #(
  parameter int unsigned DEB_CYCLES = 1_000_000,
  parameter int unsigned MIN_HOLD   = 2_500_000,
  parameter int unsigned OCT_MAX    = 3,
  parameter int unsigned OCT_RESET  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] key_in,
  input  logic       oct_up,
  input  logic       oct_dn,
  output logic [6:0] sel,
  output logic [1:0] octave,
  output logic       note_on,
  output logic       note_start
);

  localparam int unsigned N_KEY  = 7;
  localparam int unsigned N_IN   = N_KEY + 2;
  localparam int unsigned CNT_W  = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned HOLD_W = $clog2(MIN_HOLD + 1);

  localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MIN_HOLD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_HOLD
  } state_t;

  logic [N_IN-1:0]   w_raw;
  logic [N_IN-1:0]   r_sync1;
  logic [N_IN-1:0]   r_sync2;
  logic [N_IN-1:0]   r_deb;
  logic [N_IN-1:0]   r_deb_d;
  logic [CNT_W-1:0]  r_cnt [N_IN];

  logic [N_KEY-1:0]  w_keys;
  logic [N_KEY-1:0]  w_win;
  logic              w_any;
  logic              w_released;
  logic              w_up_rise;
  logic              w_dn_rise;

  state_t            r_state;
  logic [N_KEY-1:0]  r_sel;
  logic              r_note_on;
  logic              r_note_start;
  logic [HOLD_W-1:0] r_hold;
  logic [1:0]        r_octave;

  assign w_raw = {oct_dn, oct_up, key_in};

  // 2-FF synchroniser plus per-input stability counter; a mismatch run of
  // DEB_CYCLES synced samples flips the debounced value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      for (int i = 0; i < int'(N_IN); i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      for (int i = 0; i < int'(N_IN); i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DEB_LAST) begin
          r_deb[i] <= ~r_deb[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign w_keys     = r_deb[N_KEY-1:0];
  assign w_any      = |w_keys;
  assign w_released = (w_keys & r_sel) == '0;

  // Highest-index debounced key wins (C over D over ... over B).
  always_comb begin
    w_win = '0;
    for (int i = 0; i < int'(N_KEY); i++) begin
      if (w_keys[i]) begin
        w_win    = '0;
        w_win[i] = 1'b1;
      end
    end
  end

  // Note FSM: the latched note plays at least MIN_HOLD cycles; HOLD covers an
  // early release and ignores every key until the minimum length has elapsed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_sel        <= '0;
      r_note_on    <= 1'b0;
      r_note_start <= 1'b0;
      r_hold       <= '0;
    end else begin
      r_note_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state      <= S_PLAY;
            r_sel        <= w_win;
            r_note_on    <= 1'b1;
            r_note_start <= 1'b1;
            r_hold       <= '0;
          end else begin
            r_sel     <= '0;
            r_note_on <= 1'b0;
          end
        end
        S_PLAY: begin
          if (r_hold != HOLD_SAT) r_hold <= r_hold + HOLD_W'(1);
          if (w_released) begin
            if (r_hold >= HOLD_LAST) begin
              r_state   <= S_IDLE;
              r_sel     <= '0;
              r_note_on <= 1'b0;
            end else begin
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (r_hold != HOLD_SAT) r_hold <= r_hold + HOLD_W'(1);
          if (r_hold >= HOLD_LAST) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_note_on <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_sel     <= '0;
          r_note_on <= 1'b0;
        end
      endcase
    end
  end

  assign w_up_rise = r_deb[N_KEY]     & ~r_deb_d[N_KEY];
  assign w_dn_rise = r_deb[N_KEY + 1] & ~r_deb_d[N_KEY + 1];

  // Saturating octave; simultaneous up and down rising edges cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_octave <= 2'(OCT_RESET);
    end else if (w_up_rise && !w_dn_rise) begin
      if (r_octave < 2'(OCT_MAX)) r_octave <= r_octave + 2'd1;
    end else if (w_dn_rise && !w_up_rise) begin
      if (r_octave != 2'd0) r_octave <= r_octave - 2'd1;
    end
  end

  assign sel        = r_sel;
  assign octave     = r_octave;
  assign note_on    = r_note_on;
  assign note_start = r_note_start;

endmodule

// File: tb/tb_piano_key_ctrl.sv
// Directed plus random bench for piano_key_ctrl, checked every cycle against a
// history-based reference model of debounce, note timing and octave stepping.
module tb_piano_key_ctrl;

  localparam int DEB  = 4;
  localparam int MINH = 10;
  localparam int OMAX = 3;
  localparam int ORST = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] key_in = '0;
  logic       oct_up = 1'b0;
  logic       oct_dn = 1'b0;
  logic [6:0] sel;
  logic [1:0] octave;
  logic       note_on;
  logic       note_start;

  int errors = 0;
  int checks = 0;
  int ns_count = 0;

  // reference model state
  int         m_k = 0;
  logic [8:0] raw_hist [$];
  logic [8:0] syn_hist [$];
  int         last_flip [9];
  logic [8:0] m_deb = '0;
  logic [8:0] m_dd = '0;
  logic [6:0] m_sel = '0;
  logic       m_ns = 1'b0;
  logic       m_rel = 1'b0;
  int         m_start = 0;
  int         m_oct = ORST;

  piano_key_ctrl #(
    .DEB_CYCLES(DEB),
    .MIN_HOLD  (MINH),
    .OCT_MAX   (OMAX),
    .OCT_RESET (ORST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .oct_up    (oct_up),
    .oct_dn    (oct_dn),
    .sel       (sel),
    .octave    (octave),
    .note_on   (note_on),
    .note_start(note_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the reference model; raw is what the DUT sampled at that edge.
  task automatic model_edge(input logic r, input logic [8:0] raw);
    logic [8:0] syn;
    logic       all_diff;
    int         age;
    int         idx;
    logic       up;
    logic       dn;
    if (r) begin
      m_k = 0;
      raw_hist.delete();
      syn_hist.delete();
      for (int i = 0; i < 9; i++) last_flip[i] = -1;
      m_deb = '0; m_dd = '0; m_sel = '0; m_ns = 1'b0; m_rel = 1'b0;
      m_start = 0; m_oct = ORST;
    end else begin
      syn = (m_k >= 2) ? raw_hist[m_k - 2] : 9'd0;
      raw_hist.push_back(raw);
      syn_hist.push_back(syn);
      // note selection from debounced keys as they stood before this edge
      if (m_sel == 7'd0) begin
        m_ns = 1'b0;
        if (m_deb[6:0] != 7'd0) begin
          idx     = $clog2(int'(m_deb[6:0]) + 1) - 1;
          m_sel   = 7'(1 << idx);
          m_start = m_k;
          m_rel   = 1'b0;
          m_ns    = 1'b1;
        end
      end else begin
        m_ns = 1'b0;
        age  = m_k - 1 - m_start;
        if (!m_rel) begin
          if ((m_deb[6:0] & m_sel) == 7'd0) begin
            if (age >= MINH - 1) m_sel = '0;
            else m_rel = 1'b1;
          end
        end else if (age >= MINH - 1) begin
          m_sel = '0;
        end
      end
      up = m_deb[7] & ~m_dd[7];
      dn = m_deb[8] & ~m_dd[8];
      if (up && !dn && m_oct < OMAX) m_oct = m_oct + 1;
      if (dn && !up && m_oct > 0) m_oct = m_oct - 1;
      m_dd = m_deb;
      // a value is accepted after DEB consecutive differing samples since the last flip
      for (int i = 0; i < 9; i++) begin
        if (m_k - last_flip[i] >= DEB) begin
          all_diff = 1'b1;
          for (int j = m_k - DEB + 1; j <= m_k; j++)
            if (syn_hist[j][i] == m_deb[i]) all_diff = 1'b0;
          if (all_diff) begin
            m_deb[i]     = ~m_deb[i];
            last_flip[i] = m_k;
          end
        end
      end
      m_k++;
    end
  endtask

  task automatic tick();
    logic       r;
    logic [8:0] raw;
    r   = rst;
    raw = {oct_dn, oct_up, key_in};
    @(posedge clk);
    model_edge(r, raw);
    #1;
    if (note_start === 1'b1) ns_count++;
    check("sel", 8'(sel), 8'(m_sel));
    check("note_on", 8'(note_on), 8'(m_sel != 7'd0));
    check("note_start", 8'(note_start), 8'(m_ns));
    check("octave", 8'(octave), 8'(m_oct));
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic press_oct(input logic up, input logic dn);
    oct_up = up; oct_dn = dn;
    run(8);
    oct_up = 1'b0; oct_dn = 1'b0;
    run(8);
  endtask

  initial begin
    int ns0;
    int oexp_up [4];
    int oexp_dn [5];
    oexp_up = '{2, 3, 3, 3};
    oexp_dn = '{2, 1, 0, 0, 0};

    // reset
    rst = 1'b1;
    run(2);
    check("rst_sel", 8'(sel), 8'h00);
    check("rst_note_on", 8'(note_on), 8'h00);
    check("rst_note_start", 8'(note_start), 8'h00);
    check("rst_octave", 8'(octave), 8'h01);
    rst = 1'b0;
    run(3);

    // single key E: note appears on the 7th edge after the first sample
    key_in = 7'b0010000;
    ns0 = ns_count;
    run(6);
    check("e_before", 8'(sel), 8'h00);
    tick();
    check("e_sel", 8'(sel), 8'h10);
    check("e_start", 8'(note_start), 8'h01);
    run(13);
    check("e_one_pulse", 8'(ns_count - ns0), 8'h01);
    key_in = '0;
    run(12);
    check("e_off", 8'(sel), 8'h00);

    // 1-cycle glitches every 3 cycles are filtered
    ns0 = ns_count;
    for (int c = 0; c < 10; c++) begin
      key_in = 7'(1 << $urandom_range(6, 0));
      tick();
      key_in = '0;
      run(2);
      check("glitch_sel", 8'(sel), 8'h00);
    end
    check("glitch_pulses", 8'(ns_count - ns0), 8'h00);

    // G and B together -> G; adding C does not re-arbitrate
    key_in = 7'b0000101;
    run(8);
    check("chord_sel", 8'(sel), 8'h04);
    key_in = 7'b1000101;
    run(12);
    check("chord_add_c", 8'(sel), 8'h04);
    key_in = '0;
    run(14);
    check("chord_off", 8'(sel), 8'h00);

    // short E press: minimum length enforced, re-press in HOLD ignored
    key_in = 7'b0010000;
    run(4);
    key_in = '0;
    run(2);
    tick();
    check("hs_start", 8'(note_start), 8'h01);
    ns0 = ns_count;
    tick();
    key_in = 7'b0010000;
    run(8);
    check("hs_held", 8'(sel), 8'h10);
    check("hs_no_restart", 8'(ns_count - ns0), 8'h00);
    tick();
    check("hs_off", 8'(sel), 8'h00);
    tick();
    check("hs_retrigger", 8'(note_start), 8'h01);
    key_in = '0;
    run(20);

    // octave stepping and saturation
    for (int n = 0; n < 4; n++) begin
      press_oct(1'b1, 1'b0);
      check("oct_up", 8'(octave), 8'(oexp_up[n]));
    end
    for (int n = 0; n < 5; n++) begin
      press_oct(1'b0, 1'b1);
      check("oct_dn", 8'(octave), 8'(oexp_dn[n]));
    end
    press_oct(1'b1, 1'b0);
    check("oct_up_from0", 8'(octave), 8'h01);
    press_oct(1'b1, 1'b1);
    check("oct_both", 8'(octave), 8'h01);
    press_oct(1'b1, 1'b0);
    check("oct_pre_rst", 8'(octave), 8'h02);

    // reset mid-note
    key_in = 7'b1000000;
    run(8);
    check("mid_sel", 8'(sel), 8'h40);
    rst = 1'b1;
    tick();
    check("mid_rst_sel", 8'(sel), 8'h00);
    check("mid_rst_note_on", 8'(note_on), 8'h00);
    check("mid_rst_octave", 8'(octave), 8'h01);
    rst = 1'b0;
    key_in = '0;
    run(6);

    // random stimulus against the model
    for (int n = 0; n < 120; n++) begin
      key_in = ($urandom_range(3, 0) == 0) ? 7'd0 : 7'($urandom);
      oct_up = ($urandom_range(4, 0) == 0);
      oct_dn = ($urandom_range(4, 0) == 0);
      run($urandom_range(25, 1));
    end
    key_in = '0; oct_up = 1'b0; oct_dn = 1'b0;
    run(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
